// File: rtl/scan_ctrl_pkg.sv
// Shared types and geometry helpers for the scan-chain controller.
package scan_ctrl_pkg;

   typedef enum logic [1:0] {
      CAP  = 2'b00,
      RST  = 2'b01,
      SWAP = 2'b10,
      NOP  = 2'b11
   } scan_op_e;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_SHIFT,
      S_DRAIN,
      S_DONE
   } state_e;

   function automatic int unsigned nwords(input int unsigned len, input int unsigned w);
      return (len + w - 1) / w;
   endfunction

   function automatic int unsigned last_n(input int unsigned len, input int unsigned w);
      return len - (nwords(len, w) - 1) * w;
   endfunction

   function automatic int unsigned cnt_w(input int unsigned w);
      return $clog2(w + 1);
   endfunction

endpackage

// File: rtl/scan_shifter.sv
// Word-wide serial shift register with bit counter; serialises one host word
// onto the chain while collecting the bits that come back.
module scan_shifter
   import scan_ctrl_pkg::*;
#(
   parameter int unsigned WORD_W = 32,
   parameter int unsigned LAST_N = 18
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load_i,
   input  logic [WORD_W-1:0] wdata_i,
   input  logic              shift_i,
   input  logic              recirc_i,
   input  logic              last_i,
   input  logic              scan_out_i,
   output logic              scan_in_o,
   output logic              bit_last_o,
   output logic [WORD_W-1:0] rdata_o
);

   localparam int unsigned CNT_W = cnt_w(WORD_W);
   localparam int unsigned SHR   = WORD_W - LAST_N;
   localparam logic [CNT_W-1:0] FULL_END = CNT_W'(WORD_W - 1);
   localparam logic [CNT_W-1:0] LAST_END = CNT_W'(LAST_N - 1);

   logic [WORD_W-1:0] sreg_q, sreg_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   assign bit_last_o = (cnt_q == (last_i ? LAST_END : FULL_END));
   // Recirculating keeps the chain intact during capture.
   assign scan_in_o  = shift_i & (recirc_i ? scan_out_i : sreg_q[0]);
   assign rdata_o    = last_i ? (sreg_q >> SHR) : sreg_q;

   always_comb begin
      sreg_d = sreg_q;
      cnt_d  = cnt_q;
      if (load_i) begin
         sreg_d = wdata_i;
         cnt_d  = '0;
      end else if (shift_i) begin
         sreg_d = (sreg_q >> 1) | (WORD_W'(scan_out_i) << (WORD_W - 1));
         cnt_d  = bit_last_o ? '0 : cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sreg_q <= '0;
         cnt_q  <= '0;
      end else begin
         sreg_q <= sreg_d;
         cnt_q  <= cnt_d;
      end
   end

endmodule

// File: rtl/scan_ctrl.sv
// Host-side scan-chain controller: capture, restore or swap DUT state through
// the scan port while the DUT functional clock is held off.
module scan_ctrl
   import scan_ctrl_pkg::*;
#(
   parameter int unsigned CHAIN_LEN = 50,
   parameter int unsigned WORD_W    = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [1:0]        cmd_op,
   input  logic              wdata_valid,
   output logic              wdata_ready,
   input  logic [WORD_W-1:0] wdata,
   output logic              rdata_valid,
   input  logic              rdata_ready,
   output logic [WORD_W-1:0] rdata,
   output logic              rdata_last,
   output logic              busy,
   output logic              done,
   output logic              dut_clk_en,
   output logic              scan_enable,
   output logic              scan_in,
   input  logic              scan_out
);

   localparam int unsigned NWORDS = nwords(CHAIN_LEN, WORD_W);
   localparam int unsigned LAST_N = last_n(CHAIN_LEN, WORD_W);
   localparam int unsigned WC_W   = (NWORDS > 1) ? $clog2(NWORDS) : 1;
   localparam logic [WC_W-1:0] LAST_WORD = WC_W'(NWORDS - 1);

   state_e            state_q, state_d;
   scan_op_e          op_q, op_d;
   logic [WC_W-1:0]   word_q, word_d;
   logic              last_word;
   logic              load, shift, bit_last;

   assign last_word  = (word_q == LAST_WORD);
   assign rdata_last = rdata_valid & last_word;

   scan_shifter #(
      .WORD_W (WORD_W),
      .LAST_N (LAST_N)
   ) u_shifter (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_i     (load),
      .wdata_i    (wdata),
      .shift_i    (shift),
      .recirc_i   (op_q == CAP),
      .last_i     (last_word),
      .scan_out_i (scan_out),
      .scan_in_o  (scan_in),
      .bit_last_o (bit_last),
      .rdata_o    (rdata)
   );

   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      word_d      = word_q;
      cmd_ready   = 1'b0;
      wdata_ready = 1'b0;
      rdata_valid = 1'b0;
      busy        = 1'b1;
      done        = 1'b0;
      dut_clk_en  = 1'b0;
      scan_enable = 1'b0;
      load        = 1'b0;
      shift       = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            cmd_ready  = 1'b1;
            busy       = 1'b0;
            dut_clk_en = 1'b1;
            if (cmd_valid) begin
               op_d   = scan_op_e'(cmd_op);
               word_d = '0;
               case (scan_op_e'(cmd_op))
                  CAP:       state_d = S_SHIFT;
                  RST, SWAP: state_d = S_LOAD;
                  default:   state_d = S_DONE;
               endcase
            end
         end
         S_LOAD: begin
            wdata_ready = 1'b1;
            if (wdata_valid) begin
               load    = 1'b1;
               state_d = S_SHIFT;
            end
         end
         S_SHIFT: begin
            scan_enable = 1'b1;
            shift       = 1'b1;
            if (bit_last) begin
               if (op_q != RST) begin
                  state_d = S_DRAIN;
               end else if (last_word) begin
                  state_d = S_DONE;
               end else begin
                  word_d  = word_q + WC_W'(1);
                  state_d = S_LOAD;
               end
            end
         end
         S_DRAIN: begin
            rdata_valid = 1'b1;
            if (rdata_ready) begin
               if (last_word) begin
                  state_d = S_DONE;
               end else begin
                  word_d  = word_q + WC_W'(1);
                  state_d = (op_q == CAP) ? S_SHIFT : S_LOAD;
               end
            end
         end
         S_DONE: begin
            done    = 1'b1;
            busy    = 1'b0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         op_q    <= CAP;
         word_q  <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         word_q  <= word_d;
      end
   end

endmodule
